// File: rtl/adc_pkg.sv
// Shared constants for the ADC peak-hold path: default sample width, full-scale
// limits, stream lane position and output sign-extension width.
package adc_pkg;

  localparam int unsigned ADC_WIDTH_DEF = 14;
  localparam logic signed [ADC_WIDTH_DEF-1:0] ADC_FS_MIN = {1'b1, {(ADC_WIDTH_DEF-1){1'b0}}};
  localparam logic signed [ADC_WIDTH_DEF-1:0] ADC_FS_MAX = {1'b0, {(ADC_WIDTH_DEF-1){1'b1}}};
  localparam int unsigned CH_A_LSB = 0;
  localparam int unsigned SEXT_WIDTH = 16;

endpackage

// File: rtl/adc_abs_mag.sv
// Combinational signed-to-magnitude; one extra output bit so the most negative
// sample maps to 2^(ADC_WIDTH-1) without overflow.
module adc_abs_mag
  import adc_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic signed [ADC_WIDTH-1:0] sample,
  output logic        [ADC_WIDTH:0]   mag
);

  logic signed [ADC_WIDTH:0] ext;

  always_comb begin
    ext = (ADC_WIDTH + 1)'(sample);
    mag = ext[ADC_WIDTH] ? unsigned'(-ext) : unsigned'(ext);
  end

endmodule

// File: rtl/adc_peak_hold.sv
// Per-window largest-magnitude sample detector with optional linear-decay peak hold,
// emitting one sign-extended AXI-Stream word per window of 2^LOG2_WIN accepted samples.
module adc_peak_hold
  import adc_pkg::*;
#(
  parameter int unsigned ADC_WIDTH        = ADC_WIDTH_DEF,
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned LOG2_WIN         = 10,
  parameter int unsigned DECAY            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  output logic                        overrange
);

  localparam int unsigned MagW = ADC_WIDTH + 1;
  localparam logic [LOG2_WIN-1:0] CntLast = '1;
  localparam logic [MagW-1:0] DecayMag = MagW'(DECAY);
  localparam logic signed [ADC_WIDTH-1:0] FsMin = {1'b1, {(ADC_WIDTH-1){1'b0}}};
  localparam logic signed [ADC_WIDTH-1:0] FsMax = {1'b0, {(ADC_WIDTH-1){1'b1}}};

  logic [LOG2_WIN-1:0]         cnt_q;
  logic signed [ADC_WIDTH-1:0] peak_q, peak_d;
  logic                        or_q, or_d;
  logic [MagW-1:0]             hold_mag_q, hold_mag_d;
  logic                        hold_neg_q, hold_neg_d;

  logic signed [ADC_WIDTH-1:0] sample;
  logic [MagW-1:0]             mag_in, mag_peak, peak_mag_d, decayed, decayed_signed;
  logic                        first, take_new, is_fs;
  logic signed [ADC_WIDTH-1:0] res;
  logic [SEXT_WIDTH-1:0]       res_sext;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_d;

  assign S_AXIS_tready = 1'b1;
  assign sample = S_AXIS_tdata[CH_A_LSB +: ADC_WIDTH];

  adc_abs_mag #(.ADC_WIDTH(ADC_WIDTH)) u_mag_in (
    .sample (sample),
    .mag    (mag_in)
  );

  adc_abs_mag #(.ADC_WIDTH(ADC_WIDTH)) u_mag_peak (
    .sample (peak_q),
    .mag    (mag_peak)
  );

  always_comb begin
    first      = (cnt_q == '0);
    take_new   = first || (mag_in > mag_peak);
    peak_d     = take_new ? sample : peak_q;
    peak_mag_d = take_new ? mag_in : mag_peak;
    is_fs      = (sample == FsMin) || (sample == FsMax);
    or_d       = is_fs || (!first && or_q);

    decayed        = (hold_mag_q > DecayMag) ? (hold_mag_q - DecayMag) : '0;
    decayed_signed = hold_neg_q ? (~decayed + 1'b1) : decayed;

    // A zero decayed magnitude always loses to the window peak, so a held result is never -0.
    if (DECAY == 0 || peak_mag_d >= decayed) begin
      res        = peak_d;
      hold_mag_d = peak_mag_d;
    end else begin
      res        = decayed_signed[ADC_WIDTH-1:0];
      hold_mag_d = decayed;
    end
    hold_neg_d = res[ADC_WIDTH-1];

    res_sext = SEXT_WIDTH'(res);
    tdata_d  = AXIS_TDATA_WIDTH'(res_sext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      peak_q        <= '0;
      or_q          <= 1'b0;
      hold_mag_q    <= '0;
      hold_neg_q    <= 1'b0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      overrange     <= 1'b0;
    end else begin
      M_AXIS_tvalid <= 1'b0;
      if (S_AXIS_tvalid) begin
        cnt_q  <= cnt_q + LOG2_WIN'(1);
        peak_q <= peak_d;
        or_q   <= or_d;
        if (cnt_q == CntLast) begin
          M_AXIS_tvalid <= 1'b1;
          M_AXIS_tdata  <= tdata_d;
          overrange     <= or_d;
          hold_mag_q    <= hold_mag_d;
          hold_neg_q    <= hold_neg_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_peak_hold.sv
// Drives two peak-hold instances (no decay / decay 100, 4-sample windows) with one
// stream and compares every cycle against a window-level arithmetic model.
module tb_adc_peak_hold;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        rdy0, rdy1, tv0, tv1, ovr0, ovr1;
  logic [31:0] td0, td1;

  int tests = 0;
  int fails = 0;

  int  win[$];
  int  exp_d0 = 0, exp_d1 = 0, hold1 = 0;
  bit  exp_or = 1'b0;

  always #4 clk = ~clk;

  adc_peak_hold #(.ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .LOG2_WIN(2), .DECAY(0)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (rdy0),
    .M_AXIS_tdata  (td0),
    .M_AXIS_tvalid (tv0),
    .overrange     (ovr0)
  );

  adc_peak_hold #(.ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .LOG2_WIN(2), .DECAY(100)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (rdy1),
    .M_AXIS_tdata  (td1),
    .M_AXIS_tvalid (tv1),
    .overrange     (ovr1)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] word(input int v);
    return 32'(v) & 32'h0000_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Window result from the rules: largest |x| (first wins ties), then decay/hold for dut1.
  task automatic model_window();
    int pk, dec, r;
    bit orr;
    pk  = win[0];
    orr = 1'b0;
    foreach (win[i]) begin
      if (i > 0 && iabs(win[i]) > iabs(pk)) pk = win[i];
      if (win[i] == -8192 || win[i] == 8191) orr = 1'b1;
    end
    exp_d0 = pk;
    exp_or = orr;
    dec = iabs(hold1) - 100;
    if (dec < 0) dec = 0;
    if (iabs(pk) >= dec) r = pk;
    else r = (hold1 < 0) ? -dec : dec;
    hold1  = r;
    exp_d1 = r;
  endtask

  task automatic check_outputs(input bit pulse);
    check("tready0", 32'(rdy0), 32'd1);
    check("tready1", 32'(rdy1), 32'd1);
    check("tvalid0", 32'(tv0), 32'(pulse));
    check("tvalid1", 32'(tv1), 32'(pulse));
    check("tdata0", td0, word(exp_d0));
    check("tdata1", td1, word(exp_d1));
    check("ovr0", 32'(ovr0), 32'(exp_or));
    check("ovr1", 32'(ovr1), 32'(exp_or));
  endtask

  task automatic step(input bit v, input int x);
    bit pulse;
    s_tvalid = v;
    s_tdata  = ($urandom() & 32'hFFFF_C000) | (32'(x) & 32'h0000_3FFF);
    if (!v) s_tdata = $urandom();
    @(posedge clk);
    #1;
    pulse = 1'b0;
    if (v) begin
      win.push_back(x);
      if (win.size() == 4) begin
        model_window();
        win.delete();
        pulse = 1'b1;
      end
    end
    check_outputs(pulse);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'($urandom());
    s_tdata  = $urandom();
    @(posedge clk);
    #1;
    rst = 1'b0;
    win.delete();
    exp_d0 = 0;
    exp_d1 = 0;
    hold1  = 0;
    exp_or = 1'b0;
    check_outputs(1'b0);
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    step(1'b1, a);
    step(1'b1, b);
    step(1'b1, c);
    step(1'b1, d);
  endtask

  initial begin
    int x;
    do_reset();

    window4(100, -300, 250, 50);
    check("plan_fed4", td0, 32'h0000_FED4);
    step(1'b0, 0);
    window4(200, -200, 10, 10);
    check("plan_tie", td0, 32'd200);
    window4(-8192, 0, 0, 0);
    check("plan_e000", td0, 32'h0000_E000);
    check("plan_or1", 32'(ovr0), 32'd1);
    window4(0, 0, 0, 0);
    check("plan_or0", 32'(ovr0), 32'd0);

    do_reset();
    window4(1000, 0, 0, 0);
    window4(0, 0, 0, 0);
    window4(0, 0, 0, 0);
    check("plan_800", td1, 32'd800);
    window4(0, 0, 0, 0);
    check("plan_700", td1, 32'd700);
    window4(0, -850, 0, 0);
    check("plan_m850", td1, word(-850));

    do_reset();
    window4(150, 0, 0, 0);
    window4(0, 0, 0, 0);
    check("plan_50", td1, 32'd50);
    window4(0, 0, 0, 0);
    check("plan_floor", td1, 32'd0);

    // Gapped valid: pulse only after the fourth accepted sample.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 2) ? -8191 : 7 * i);
      step(1'b0, 0);
    end

    // Partial window discarded by reset.
    step(1'b1, 5000);
    step(1'b1, -6000);
    do_reset();
    window4(12, -34, 56, -7);
    check("plan_post_rst", td0, 32'd56);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) x = $urandom_range(0, 1) ? 8191 : -8192;
      else if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 16383)) - 8192;
      else x = int'($urandom_range(0, 600)) - 300;
      if (i == 401) do_reset();
      step($urandom_range(0, 3) != 0, x);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
